xgmii_tx_framer: RTL and testbench

Transmit framing stage that sits between the MAC's packet-data/CRC FIFOs and the XGMII TX pins. It pulls 64-bit payload words from the packet-data FIFO and the finished 32-bit FCS from the CRC FIFO. It then emits the XGMII column stream: start/preamble/SFD, payload, FCS at the correct byte lane, terminate, and a guaranteed inter-frame gap. Underrun mid-frame is signalled on the line with /E/ columns.

---
 rtl/eth_xgmii_pkg.sv | 25 ++
 rtl/xgmii_tx_lane_merge.sv | 74 +++++++
 rtl/xgmii_tx_framer.sv | 159 +++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_xgmii_pkg.sv
// Shared XGMII TX definitions: control characters, preamble bytes, framer
// state encoding and idle-word helper.
package eth_xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_TERM     = 8'hFD;
    localparam logic [7:0] XGMII_ERROR    = 8'hFE;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hD5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        TAIL = 3'd3,
        IFG  = 3'd4,
        DROP = 3'd5
    } framer_state_t;

    function automatic logic [63:0] idle_word();
        return {8{XGMII_IDLE}};
    endfunction

endpackage

// File: rtl/xgmii_tx_lane_merge.sv
// Combinational lane builder for the end of a frame: places data, FCS, /T/ and
// /I/ into the last payload word and the optional following tail word.
module xgmii_tx_lane_merge
    import eth_xgmii_pkg::*;
(
    input  logic [63:0] last_data,
    input  logic [3:0]  n_bytes,
    input  logic [31:0] fcs,
    output logic [63:0] last_txd,
    output logic [7:0]  last_txc,
    output logic [63:0] tail_txd,
    output logic [7:0]  tail_txc
);

    function automatic logic [7:0] fcs_byte(input logic [31:0] f, input logic [1:0] idx);
        case (idx)
            2'd0:    return f[7:0];
            2'd1:    return f[15:8];
            2'd2:    return f[23:16];
            default: return f[31:24];
        endcase
    endfunction

    for (genvar k = 0; k < 8; k++) begin : g_lane
        localparam logic [3:0] LANE = 4'(k);
        logic [3:0] last_off_s;
        logic [3:0] tail_off_s;
        logic [7:0] last_b_s;
        logic       last_c_s;
        logic [7:0] tail_b_s;
        logic       tail_c_s;

        // FCS byte index this lane would carry in each word
        assign last_off_s = LANE - n_bytes;
        assign tail_off_s = LANE + 4'd8 - n_bytes;

        // Lane content of the word holding the final payload bytes
        always_comb begin
            if (LANE < n_bytes) begin
                last_b_s = last_data[8*k +: 8];
                last_c_s = 1'b0;
            end else if (LANE < n_bytes + 4'd4) begin
                last_b_s = fcs_byte(fcs, last_off_s[1:0]);
                last_c_s = 1'b0;
            end else if (LANE == n_bytes + 4'd4) begin
                last_b_s = XGMII_TERM;
                last_c_s = 1'b1;
            end else begin
                last_b_s = XGMII_IDLE;
                last_c_s = 1'b1;
            end
        end

        // Lane content of the overflow word used when n >= 4
        always_comb begin
            if (LANE + 4'd4 < n_bytes) begin
                tail_b_s = fcs_byte(fcs, tail_off_s[1:0]);
                tail_c_s = 1'b0;
            end else if (LANE + 4'd4 == n_bytes) begin
                tail_b_s = XGMII_TERM;
                tail_c_s = 1'b1;
            end else begin
                tail_b_s = XGMII_IDLE;
                tail_c_s = 1'b1;
            end
        end

        assign last_txd[8*k +: 8] = last_b_s;
        assign last_txc[k]        = last_c_s;
        assign tail_txd[8*k +: 8] = tail_b_s;
        assign tail_txc[k]        = tail_c_s;
    end

endmodule

// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps FIFO payload words and FCS into start/preamble,
// data, terminate and inter-frame gap columns, with /E/ signalling on underrun.
module xgmii_tx_framer
    import eth_xgmii_pkg::*;
#(
    parameter int unsigned IFG_WORDS = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        pd_valid,
    output logic        pd_ready,
    input  logic [63:0] pd_data,
    input  logic        pd_last,
    input  logic [2:0]  pd_bytes,
    input  logic        crc_valid,
    output logic        crc_ready,
    input  logic [31:0] crc_data,
    output logic [63:0] TXD,
    output logic [7:0]  TXC,
    output logic        frame_done,
    output logic        underrun
);

    framer_state_t state_r, state_s;
    logic [3:0]  ifg_cnt_r, ifg_cnt_s;
    logic [3:0]  nbytes_r, n_live_s, merge_n_s;
    logic [31:0] fcs_r, merge_fcs_s;
    logic [63:0] txd_s, last_txd_s, tail_txd_s;
    logic [7:0]  txc_s, last_txc_s, tail_txc_s;
    logic        done_s, underrun_s, pd_ready_s, crc_ready_s, latch_s;

    assign n_live_s    = (pd_bytes == 3'd0) ? 4'd8 : {1'b0, pd_bytes};
    // TAIL works from the values latched on the last data beat
    assign merge_n_s   = (state_r == TAIL) ? nbytes_r : n_live_s;
    assign merge_fcs_s = (state_r == TAIL) ? fcs_r : crc_data;

    xgmii_tx_lane_merge u_merge (
        .last_data (pd_data),
        .n_bytes   (merge_n_s),
        .fcs       (merge_fcs_s),
        .last_txd  (last_txd_s),
        .last_txc  (last_txc_s),
        .tail_txd  (tail_txd_s),
        .tail_txc  (tail_txc_s)
    );

    // Next-state, next-column and FIFO handshake decode
    always_comb begin
        state_s     = state_r;
        ifg_cnt_s   = ifg_cnt_r;
        txd_s       = idle_word();
        txc_s       = 8'hFF;
        done_s      = 1'b0;
        underrun_s  = 1'b0;
        pd_ready_s  = 1'b0;
        crc_ready_s = 1'b0;
        latch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_en && pd_valid && crc_valid) begin
                    state_s = PRE;
                end else begin
                    state_s = IDLE;
                end
            end
            PRE: begin
                txd_s   = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
                txc_s   = 8'h01;
                state_s = DATA;
            end
            DATA: begin
                if (!pd_valid) begin
                    txd_s      = {8{XGMII_ERROR}};
                    txc_s      = 8'hFF;
                    underrun_s = 1'b1;
                    state_s    = DROP;
                end else if (pd_last) begin
                    pd_ready_s  = 1'b1;
                    crc_ready_s = 1'b1;
                    latch_s     = 1'b1;
                    txd_s       = last_txd_s;
                    txc_s       = last_txc_s;
                    if (n_live_s <= 4'd3) begin
                        done_s    = 1'b1;
                        ifg_cnt_s = 4'd0;
                        state_s   = IFG;
                    end else begin
                        state_s = TAIL;
                    end
                end else begin
                    pd_ready_s = 1'b1;
                    txd_s      = pd_data;
                    txc_s      = 8'h00;
                end
            end
            TAIL: begin
                txd_s     = tail_txd_s;
                txc_s     = tail_txc_s;
                done_s    = 1'b1;
                ifg_cnt_s = 4'd0;
                state_s   = IFG;
            end
            IFG: begin
                if (ifg_cnt_r == 4'(IFG_WORDS - 1)) begin
                    ifg_cnt_s = 4'd0;
                    state_s   = IDLE;
                end else begin
                    ifg_cnt_s = ifg_cnt_r + 4'd1;
                end
            end
            DROP: begin
                pd_ready_s = 1'b1;
                txd_s      = {8{XGMII_ERROR}};
                txc_s      = 8'hFF;
                if (pd_valid && pd_last) begin
                    crc_ready_s = 1'b1;
                    ifg_cnt_s   = 4'd0;
                    state_s     = IFG;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign pd_ready  = pd_ready_s;
    assign crc_ready = crc_ready_s;

    // State, latched frame tail and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ifg_cnt_r  <= 4'd0;
            nbytes_r   <= 4'd0;
            fcs_r      <= 32'd0;
            TXD        <= idle_word();
            TXC        <= 8'hFF;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_r    <= state_s;
            ifg_cnt_r  <= ifg_cnt_s;
            TXD        <= txd_s;
            TXC        <= txc_s;
            frame_done <= done_s;
            underrun   <= underrun_s;
            if (latch_s) begin
                nbytes_r <= n_live_s;
                fcs_r    <= crc_data;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Self-checking bench for xgmii_tx_framer: FIFO-style stimulus against a
// byte-stream reference of the expected XGMII column sequence.
module tb_xgmii_tx_framer;
    import eth_xgmii_pkg::*;

    localparam int IFG_W = 2;
    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;

    logic        clk = 1'b0;
    logic        rst, tx_en, pd_valid, pd_ready, pd_last, crc_valid, crc_ready;
    logic [63:0] pd_data;
    logic [2:0]  pd_bytes;
    logic [31:0] crc_data;
    logic [63:0] TXD;
    logic [7:0]  TXC;
    logic        frame_done, underrun;

    always #5 clk = ~clk;

    xgmii_tx_framer #(.IFG_WORDS(IFG_W)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en),
        .pd_valid(pd_valid), .pd_ready(pd_ready), .pd_data(pd_data),
        .pd_last(pd_last), .pd_bytes(pd_bytes),
        .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_data(crc_data),
        .TXD(TXD), .TXC(TXC), .frame_done(frame_done), .underrun(underrun)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [2:0]  bytes;
        logic        bubble;
    } beat_t;

    typedef struct packed {
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        done;
        logic        ur;
    } col_t;

    beat_t       pd_q[$];
    logic [31:0] crc_q[$];
    col_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          locked = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_col(input logic [63:0] d, input logic [7:0] c, input logic dn, input logic u);
        col_t e;
        e.txd = d; e.txc = c; e.done = dn; e.ur = u;
        exp_q.push_back(e);
    endtask

    // Queue one frame on the FIFOs and append its expected line columns.
    task automatic gen_frame(input int len, input int nb, input int bub_k, input logic [31:0] f);
        beat_t       b;
        logic [63:0] w, sh, d;
        logic [7:0]  c;
        logic [7:0]  bq[$];
        logic        cq[$];
        int          chunks;
        crc_q.push_back(f);
        push_col(PRE_W, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            w = {$urandom, $urandom};
            b.data = w; b.last = (i == len - 1); b.bytes = 3'(nb % 8); b.bubble = 1'b0;
            pd_q.push_back(b);
            if (bub_k >= 0 && i > bub_k) begin
                push_col(ERR_W, 8'hFF, 1'b0, 1'b0);
            end else if (i < len - 1) begin
                push_col(w, 8'h00, 1'b0, 1'b0);
            end else begin
                for (int j = 0; j < nb; j++) begin
                    sh = w >> (8 * j); bq.push_back(sh[7:0]); cq.push_back(1'b0);
                end
                for (int j = 0; j < 4; j++) begin
                    sh = 64'(f) >> (8 * j); bq.push_back(sh[7:0]); cq.push_back(1'b0);
                end
                bq.push_back(8'hFD); cq.push_back(1'b1);
                while (bq.size() % 8 != 0) begin
                    bq.push_back(8'h07); cq.push_back(1'b1);
                end
                chunks = bq.size() / 8;
                for (int ch = 0; ch < chunks; ch++) begin
                    d = 64'd0; c = 8'd0;
                    for (int j = 0; j < 8; j++) begin
                        d = d | (64'(bq[8*ch+j]) << (8 * j));
                        c[j] = cq[8*ch+j];
                    end
                    push_col(d, c, ch == chunks - 1, 1'b0);
                end
            end
            if (i == bub_k) begin
                b.bubble = 1'b1; b.last = 1'b0;
                pd_q.push_back(b);
                push_col(ERR_W, 8'hFF, 1'b0, 1'b1);
            end
        end
        repeat (IFG_W + 1) push_col(IDLE_W, 8'hFF, 1'b0, 1'b0);
    endtask

    // One clock: compare the registered outputs, then drive the FIFO heads.
    task automatic step();
        col_t e;
        @(negedge clk);
        if (!locked && TXD !== IDLE_W) locked = 1'b1;
        if (locked && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("txd", TXD, e.txd);
            check_val("txc", 64'(TXC), 64'(e.txc));
            check_val("frame_done", 64'(frame_done), 64'(e.done));
            check_val("underrun", 64'(underrun), 64'(e.ur));
        end
        if (pd_q.size() > 0 && !pd_q[0].bubble) begin
            pd_valid = 1'b1; pd_data = pd_q[0].data;
            pd_last = pd_q[0].last; pd_bytes = pd_q[0].bytes;
        end else begin
            pd_valid = 1'b0; pd_data = {$urandom, $urandom};
            pd_last = 1'b0; pd_bytes = 3'd0;
        end
        crc_valid = (crc_q.size() > 0);
        crc_data  = (crc_q.size() > 0) ? crc_q[0] : 32'd0;
        #1;
        if (pd_q.size() > 0) begin
            if (pd_q[0].bubble || pd_ready) void'(pd_q.pop_front());
        end
        if (crc_ready && crc_q.size() > 0) void'(crc_q.pop_front());
    endtask

    task automatic run_phase();
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            step();
            n++;
        end
        check_val("phase_drained", 64'(exp_q.size()), 64'd0);
        locked = 1'b0;
    endtask

    task automatic run_random(input int nframes);
        int len, nb, bub;
        for (int k = 0; k < nframes; k++) begin
            len = int'($urandom_range(1, 10));
            nb  = int'($urandom_range(1, 8));
            bub = (len > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 2)) : -1;
            gen_frame(len, nb, bub, $urandom);
        end
        run_phase();
    endtask

    initial begin
        int seen;
        int n;
        rst = 1'b1; tx_en = 1'b0; pd_valid = 1'b0; pd_data = 64'd0; pd_last = 1'b0;
        pd_bytes = 3'd0; crc_valid = 1'b0; crc_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_txd", TXD, IDLE_W);
        check_val("rst_txc", 64'(TXC), 64'hFF);
        check_val("rst_done", 64'(frame_done), 64'd0);
        check_val("rst_underrun", 64'(underrun), 64'd0);
        check_val("rst_pd_ready", 64'(pd_ready), 64'd0);
        rst = 1'b0; tx_en = 1'b1;

        // Directed frames back-to-back: n=8, n=3, n=5, then an underrun.
        gen_frame(8, 8, -1, 32'hDEADBEEF);
        gen_frame(3, 3, -1, 32'hDEADBEEF);
        gen_frame(4, 5, -1, 32'hDEADBEEF);
        gen_frame(6, 8, 2, 32'hDEADBEEF);
        gen_frame(1, 1, -1, 32'h01234567);
        gen_frame(2, 4, 0, 32'h89ABCDEF);
        run_phase();

        run_random(20);

        // Reset in the middle of a payload.
        gen_frame(6, 8, -1, $urandom);
        seen = 0; n = 0;
        while (seen < 2 && n < 100) begin
            step();
            if (pd_ready) seen++;
            n++;
        end
        check_val("reached_data", 64'(seen), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_txd", TXD, IDLE_W);
        check_val("midrst_txc", 64'(TXC), 64'hFF);
        check_val("midrst_done", 64'(frame_done), 64'd0);
        check_val("midrst_pd_ready", 64'(pd_ready), 64'd0);
        rst = 1'b0;
        pd_q.delete(); crc_q.delete(); exp_q.delete();
        locked = 1'b0;

        run_random(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
